transport_ip_arbiter: RTL and testbench

//  N-channel successor to the UDP/TCP-to-IP combiner. Each channel takes the word stream of one

---
 rtl/transport_ip_arbiter_pkg.sv | 21 ++
 rtl/transport_ip_arbiter_if.sv | 32 +++
 rtl/transport_ip_arbiter_chan_pkt_fifo.sv | 96 +++++++++
 rtl/transport_ip_arbiter.sv | 102 ++++++++++
 tb/tb_transport_ip_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/transport_ip_arbiter_pkg.sv
// Shared constants and types for the transport-to-IP round-robin combiner.
package transport_ip_arbiter_pkg;
  localparam logic [7:0] PROTO_TCP = 8'd6;
  localparam logic [7:0] PROTO_UDP = 8'd17;
  localparam int LEN_W   = 16;
  localparam int CSUM_W  = 16;
  localparam int PROTO_W = 8;
  localparam int CHAN_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ANNOUNCE = 2'd1,
    ST_STREAM   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [CSUM_W-1:0]  chksum;
    logic [PROTO_W-1:0] proto;
  } desc_t;
endpackage

// File: rtl/transport_ip_arbiter_if.sv
// Channel-side word streams plus the single IP-encoder-facing descriptor/payload port.
interface transport_ip_arbiter_if
  import transport_ip_arbiter_pkg::*;
#(parameter int N_CH = 2, parameter int DATA_W = 32);
  logic [N_CH-1:0]              in_wr_en;
  logic [N_CH-1:0][DATA_W-1:0]  in_data;
  logic [N_CH-1:0]              in_fin;
  logic [N_CH-1:0][LEN_W-1:0]   in_len;
  logic [N_CH-1:0][CSUM_W-1:0]  in_chksum;
  logic [N_CH-1:0][PROTO_W-1:0] in_proto;
  logic                         out_start;
  logic [CHAN_W-1:0]            out_chan;
  logic [LEN_W-1:0]             out_len;
  logic [CSUM_W-1:0]            out_chksum;
  logic [PROTO_W-1:0]           out_proto;
  logic                         out_valid;
  logic [DATA_W-1:0]            out_data;
  logic                         out_last;
  logic                         out_ready;
  logic [N_CH-1:0]              drop;

  modport master (
    output in_wr_en, in_data, in_fin, in_len, in_chksum, in_proto, out_ready,
    input  out_start, out_chan, out_len, out_chksum, out_proto,
           out_valid, out_data, out_last, drop
  );
  modport slave (
    input  in_wr_en, in_data, in_fin, in_len, in_chksum, in_proto, out_ready,
    output out_start, out_chan, out_len, out_chksum, out_proto,
           out_valid, out_data, out_last, drop
  );
endinterface

// File: rtl/transport_ip_arbiter_chan_pkt_fifo.sv
// Per-channel packet FIFO: words are only visible to the reader once committed at fin;
// a bad, empty or colliding packet is rewound and reported with a one-cycle drop pulse.
module chan_pkt_fifo
  import transport_ip_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fin,
  input  desc_t             fin_desc,
  input  logic              rd_inc,
  input  logic              rel,
  output logic              pending,
  output desc_t             desc,
  output logic [ADDR_W:0]   cnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              drop
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic bad_q, bad_d, pend_q, pend_d, drop_q, drop_d;
  desc_t desc_q, desc_d;
  logic full, wr_ok, bad_now, drop_now;
  logic [ADDR_W:0] wr_next, words;

  assign full     = (wr_ptr_q - rd_ptr_q) == FULL_CNT;
  assign wr_ok    = wr_en && !full;
  assign bad_now  = bad_q || (wr_en && full);
  // The word strobed alongside fin is counted in the packet being closed.
  assign wr_next  = wr_ptr_q + {{ADDR_W{1'b0}}, wr_ok};
  assign words    = wr_next - cmt_ptr_q;
  // A release in the same cycle frees the slot, so the new packet is accepted.
  assign drop_now = fin && (bad_now || words == '0 || (pend_q && !rel));

  always_comb begin
    wr_ptr_d  = wr_next;
    cmt_ptr_d = cmt_ptr_q;
    rd_ptr_d  = rd_ptr_q + {{ADDR_W{1'b0}}, rd_inc};
    cnt_d     = cnt_q - {{ADDR_W{1'b0}}, rd_inc};
    bad_d     = bad_now;
    pend_d    = pend_q && !rel;
    desc_d    = desc_q;
    drop_d    = 1'b0;
    if (fin) begin
      bad_d = 1'b0;
      if (drop_now) begin
        wr_ptr_d = cmt_ptr_q;
        drop_d   = 1'b1;
      end else begin
        cmt_ptr_d = wr_next;
        desc_d    = fin_desc;
        cnt_d     = words;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      bad_q     <= 1'b0;
      pend_q    <= 1'b0;
      desc_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      bad_q     <= bad_d;
      pend_q    <= pend_d;
      desc_q    <= desc_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

  assign pending = pend_q;
  assign desc    = desc_q;
  assign cnt     = cnt_q;
  assign rd_data = mem[rd_ptr_q[ADDR_W-1:0]];
  assign drop    = drop_q;
endmodule

// File: rtl/transport_ip_arbiter.sv
// Round-robin combiner: one packet FIFO per transport channel, whole packets forwarded
// one at a time to a single IP encoder input.
module transport_ip_arbiter
  import transport_ip_arbiter_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  transport_ip_arbiter_if.slave  bus
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]             pend, rd_inc, rel;
  desc_t [N_CH-1:0]            desc;
  logic [N_CH-1:0][ADDR_W:0]   cnt;
  logic [N_CH-1:0][DATA_W-1:0] rd_data;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    desc_t fin_desc;
    assign fin_desc.len    = bus.in_len[gi];
    assign fin_desc.chksum = bus.in_chksum[gi];
    assign fin_desc.proto  = bus.in_proto[gi];
    chan_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
      .clk(clk), .rst_n(reset),
      .wr_en(bus.in_wr_en[gi]), .wr_data(bus.in_data[gi]),
      .fin(bus.in_fin[gi]), .fin_desc(fin_desc),
      .rd_inc(rd_inc[gi]), .rel(rel[gi]),
      .pending(pend[gi]), .desc(desc[gi]), .cnt(cnt[gi]),
      .rd_data(rd_data[gi]), .drop(bus.drop[gi])
    );
  end

  arb_state_e    state_q, state_d;
  logic [CW-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic          pick_ok;

  // First pending channel strictly after the last grant, wrapping.
  always_comb begin : pick_blk
    int idx;
    idx     = 0;
    pick_ok = 1'b0;
    pick    = last_q;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_q) + k) % N_CH;
      if (!pick_ok && pend[idx]) begin
        pick_ok = 1'b1;
        pick    = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rd_inc  = '0;
    rel     = '0;
    case (state_q)
      ST_IDLE: if (pick_ok) begin
        grant_d = pick;
        state_d = ST_ANNOUNCE;
      end
      ST_ANNOUNCE: if (bus.out_ready) state_d = ST_STREAM;
      ST_STREAM: if (bus.out_ready) begin
        rd_inc[grant_q] = 1'b1;
        if (cnt[grant_q] == (ADDR_W+1)'(1)) begin
          rel[grant_q] = 1'b1;
          last_d       = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= CW'(N_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  logic busy;
  assign busy           = state_q != ST_IDLE;
  assign bus.out_start  = state_q == ST_ANNOUNCE;
  assign bus.out_valid  = state_q == ST_STREAM;
  assign bus.out_chan   = busy ? CHAN_W'(grant_q) : '0;
  assign bus.out_len    = busy ? desc[grant_q].len : '0;
  assign bus.out_chksum = busy ? desc[grant_q].chksum : '0;
  assign bus.out_proto  = busy ? desc[grant_q].proto : '0;
  assign bus.out_data   = bus.out_valid ? rd_data[grant_q] : '0;
  assign bus.out_last   = bus.out_valid && cnt[grant_q] == (ADDR_W+1)'(1);
endmodule

// File: tb/tb_transport_ip_arbiter.sv
// Directed bench for the transport-to-IP arbiter with 2 channels and 8-word FIFOs.
module tb_transport_ip_arbiter;
  import transport_ip_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  transport_ip_arbiter_if #(.N_CH(2), .DATA_W(32)) bus();

  transport_ip_arbiter #(.N_CH(2), .DATA_W(32), .DEPTH(8)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_wr_en = '0; bus.in_data = '0; bus.in_fin = '0;
    bus.in_len = '0; bus.in_chksum = '0; bus.in_proto = '0;
  endtask

  // n words base, base+1, ...; fin rides on the last word.
  task automatic send(input int ch, input int n, input logic [31:0] base,
                      input logic [15:0] len, input logic [15:0] cs, input logic [7:0] proto);
    for (int j = 0; j < n; j++) begin
      bus.in_wr_en[ch] = 1'b1;
      bus.in_data[ch]  = base + 32'(j);
      if (j == n - 1) begin
        bus.in_fin[ch] = 1'b1; bus.in_len[ch] = len;
        bus.in_chksum[ch] = cs; bus.in_proto[ch] = proto;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic expect_pkt(input string tag, input int ch, input int n, input logic [31:0] base,
                            input logic [15:0] len, input logic [15:0] cs, input logic [7:0] proto);
    int w;
    w = 0;
    while (!bus.out_start && w < 20) begin tick(); w++; end
    chk({tag, "_start"}, bus.out_start, 1'b1);
    if (!bus.out_start) return;
    chk({tag, "_chan"}, bus.out_chan, 3'(ch));
    chk({tag, "_len"}, bus.out_len, len);
    chk({tag, "_cs"}, bus.out_chksum, cs);
    chk({tag, "_proto"}, bus.out_proto, proto);
    bus.out_ready = 1'b1;
    tick();
    for (int j = 0; j < n; j++) begin
      chk({tag, "_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_data"}, bus.out_data, base + 32'(j));
      chk({tag, "_last"}, bus.out_last, (j == n - 1));
      tick();
    end
    chk({tag, "_end"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    idle_inputs();
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("rst_start", bus.out_start, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 32'h0);
    chk("rst_chan", bus.out_chan, 3'h0);
    chk("rst_drop", bus.drop, 2'b00);
    rst_n = 1'b1;
    tick();

    // 1: UDP packet on ch0, exact latency and word order
    send(0, 3, 32'hA000_0001, 16'd12, 16'hBEEF, PROTO_UDP);
    chk("t1_lat1", bus.out_start, 1'b0);
    chk("t1_drop", bus.drop, 2'b00);
    tick();
    chk("t1_lat2", bus.out_start, 1'b1);
    expect_pkt("t1", 0, 3, 32'hA000_0001, 16'd12, 16'hBEEF, PROTO_UDP);

    // 2: simultaneous pending after reset, round-robin order kept across repeats
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    bus.in_wr_en = 2'b11; bus.in_data[0] = 32'h20; bus.in_data[1] = 32'h30;
    bus.in_fin = 2'b11; bus.in_len[0] = 16'd4; bus.in_len[1] = 16'd4;
    bus.in_chksum[0] = 16'h1111; bus.in_chksum[1] = 16'h2222;
    bus.in_proto[0] = PROTO_UDP; bus.in_proto[1] = PROTO_TCP;
    tick(); idle_inputs();
    expect_pkt("t2a0", 0, 1, 32'h20, 16'd4, 16'h1111, PROTO_UDP);
    expect_pkt("t2a1", 1, 1, 32'h30, 16'd4, 16'h2222, PROTO_TCP);
    bus.in_wr_en = 2'b11; bus.in_data[0] = 32'h21; bus.in_data[1] = 32'h31;
    bus.in_fin = 2'b11; bus.in_len[0] = 16'd4; bus.in_len[1] = 16'd4;
    bus.in_chksum[0] = 16'h3333; bus.in_chksum[1] = 16'h4444;
    bus.in_proto[0] = PROTO_UDP; bus.in_proto[1] = PROTO_TCP;
    tick(); idle_inputs();
    expect_pkt("t2b0", 0, 1, 32'h21, 16'd4, 16'h3333, PROTO_UDP);
    expect_pkt("t2b1", 1, 1, 32'h31, 16'd4, 16'h4444, PROTO_TCP);

    // 3: overflow drop on ch1, then a clean packet
    send(1, 10, 32'h300, 16'd40, 16'h5555, PROTO_TCP);
    chk("t3_drop", bus.drop, 2'b10);
    tick();
    chk("t3_drop_clr", bus.drop, 2'b00);
    tick();
    chk("t3_nostart", bus.out_start, 1'b0);
    send(1, 2, 32'h350, 16'd8, 16'h6666, PROTO_TCP);
    expect_pkt("t3", 1, 2, 32'h350, 16'd8, 16'h6666, PROTO_TCP);

    // 4: backpressure mid-packet
    send(0, 4, 32'h400, 16'd16, 16'h7777, PROTO_UDP);
    tick();
    chk("t4_start", bus.out_start, 1'b1);
    tick();
    chk("t4_w0", bus.out_data, 32'h400);
    tick(); bus.out_ready = 1'b0;
    chk("t4_w1a", bus.out_data, 32'h401);
    tick();
    chk("t4_w1b", bus.out_data, 32'h401);
    chk("t4_v1b", bus.out_valid, 1'b1);
    tick(); bus.out_ready = 1'b1;
    chk("t4_w1c", bus.out_data, 32'h401);
    tick();
    chk("t4_w2", bus.out_data, 32'h402);
    chk("t4_l2", bus.out_last, 1'b0);
    tick();
    chk("t4_w3", bus.out_data, 32'h403);
    chk("t4_l3", bus.out_last, 1'b1);
    tick();
    chk("t4_end", bus.out_valid, 1'b0);

    // 5: second packet on a channel already holding one is dropped; first intact
    bus.out_ready = 1'b0;
    send(0, 2, 32'h500, 16'd8, 16'h8888, PROTO_UDP);
    tick();
    chk("t5_start", bus.out_start, 1'b1);
    send(0, 1, 32'h5F0, 16'd4, 16'h9999, PROTO_TCP);
    chk("t5_drop", bus.drop, 2'b01);
    expect_pkt("t5", 0, 2, 32'h500, 16'd8, 16'h8888, PROTO_UDP);

    // 6: reset during STREAM
    send(1, 3, 32'h600, 16'd12, 16'hAAAA, PROTO_TCP);
    tick(); tick(); tick();
    chk("t6_mid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", bus.out_valid, 1'b0);
    chk("t6_start", bus.out_start, 1'b0);
    chk("t6_data", bus.out_data, 32'h0);
    chk("t6_last", bus.out_last, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    send(0, 1, 32'h700, 16'd4, 16'hBBBB, PROTO_UDP);
    expect_pkt("t6", 0, 1, 32'h700, 16'd4, 16'hBBBB, PROTO_UDP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
